instruction_fetch_sequencer: RTL and testbench

- Control-side stage directly upstream of the address register file.
- Selects PC onto the address register file's OutD port and issues byte-wide memory reads at that address.
- Steps PC through the address register file's FunSel/RegSel controls and assembles two bytes into a 16-bit instruction.
- Presents the instruction to the decoder over a valid/ready handshake.

---
 rtl/instruction_fetch_sequencer_pkg.sv | 33 +++
 rtl/instruction_fetch_sequencer_if.sv | 42 ++++
 rtl/instruction_fetch_sequencer_wait_timer.sv | 24 ++
 rtl/instruction_fetch_sequencer.sv | 102 ++++++++++
 tb/tb_instruction_fetch_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared types and register-file control codes for the instruction fetch sequencer.
// Optional feature macro: FETCH_TIMEOUT_EN adds the ERROR state.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    VALID = 3'd3,
    DRAIN = 3'd4
`ifdef FETCH_TIMEOUT_EN
    , ERROR = 3'd5
`endif
  } state_t;

  // Address register file FunSel codes
  localparam logic [2:0] FUN_DEC  = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_CLR  = 3'b011;

  // Active-low register enables {PC,AR,SP}
  localparam logic [2:0] REGSEL_NONE = 3'b111;
  localparam logic [2:0] REGSEL_PC   = 3'b011;

  localparam logic [1:0] OUTSEL_PC = 2'b00;

  // States in which a memory read is outstanding
  function automatic logic is_wait(input state_t s);
    return (s == RD_LO) || (s == RD_HI) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// Fetch-side bus: control inputs, register-file controls, memory read port, decoder handshake.
// FetchErr exists only when FETCH_TIMEOUT_EN is defined.
interface instruction_fetch_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic                  Start;
  logic                  Flush;
  logic [ADDR_W-1:0]     AddrIn;
  logic [1:0]            ArfOutDSel;
  logic [2:0]            ArfFunSel;
  logic [2:0]            ArfRegSel;
  logic [ADDR_W-1:0]     MemAddr;
  logic                  MemReq;
  logic                  MemAck;
  logic [DATA_W-1:0]     MemData;
  logic [2*DATA_W-1:0]   Inst;
  logic                  InstValid;
  logic                  InstReady;
  logic                  Busy;
`ifdef FETCH_TIMEOUT_EN
  logic                  FetchErr;
`endif

  // Sequencer side
  modport master (
    input  Start, Flush, AddrIn, MemAck, MemData, InstReady,
    output ArfOutDSel, ArfFunSel, ArfRegSel, MemAddr, MemReq, Inst, InstValid, Busy
`ifdef FETCH_TIMEOUT_EN
    , output FetchErr
`endif
  );

  // Environment side (register file, memory, decoder)
  modport slave (
    output Start, Flush, AddrIn, MemAck, MemData, InstReady,
    input  ArfOutDSel, ArfFunSel, ArfRegSel, MemAddr, MemReq, Inst, InstValid, Busy
`ifdef FETCH_TIMEOUT_EN
    , input FetchErr
`endif
  );
endinterface

// File: rtl/instruction_fetch_sequencer_wait_timer.sv
// fetch_wait_timer: counts cycles spent waiting for MemAck; flags the last allowed wait cycle.
module fetch_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic Clock,
  input  logic ResetN,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Wait counter; a state change restarts the count
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)  cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  // This wait cycle brings the count to TIMEOUT_CYCLES
  assign expired = inc && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: reads two bytes at PC (little-endian), bumps PC through
// the address register file, and hands the 16-bit instruction to the decoder.
// Optional feature macro: FETCH_TIMEOUT_EN (wait timeout -> ERROR state, FetchErr output).
module instruction_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          Clock,
  input  logic                          ResetN,
  instruction_fetch_sequencer_if.master bus
);
  state_t                state, state_nxt;
  logic [2*DATA_W-1:0]   inst_q;
  logic                  cap_lo, cap_hi;
  logic [2:0]            fun_sel, reg_sel;
  logic                  expired;

`ifdef FETCH_TIMEOUT_EN
  fetch_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .clr     (state_nxt != state),
    .inc     (is_wait(state) && !bus.MemAck),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // State register
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state, byte capture strobes and the one-cycle PC increment on an accepted byte
  always_comb begin
    state_nxt = state;
    cap_lo    = 1'b0;
    cap_hi    = 1'b0;
    fun_sel   = FUN_DEC;
    reg_sel   = REGSEL_NONE;
    unique case (state)
      IDLE: if (!bus.Flush && bus.Start) state_nxt = RD_LO;
      RD_LO, RD_HI: begin
        if (bus.Flush) begin
          // An ack in the flush cycle completes the read, so nothing is left to drain
          state_nxt = bus.MemAck ? IDLE : DRAIN;
        end else if (bus.MemAck) begin
          fun_sel   = FUN_INC;
          reg_sel   = REGSEL_PC;
          cap_lo    = (state == RD_LO);
          cap_hi    = (state == RD_HI);
          state_nxt = (state == RD_LO) ? RD_HI : VALID;
        end else if (expired) begin
`ifdef FETCH_TIMEOUT_EN
          state_nxt = ERROR;
`endif
        end
      end
      VALID: begin
        if (bus.Flush)          state_nxt = IDLE;
        else if (bus.InstReady) state_nxt = bus.Start ? RD_LO : IDLE;
      end
      // The outstanding read cannot be retracted; Flush has nothing more to abort here
      DRAIN: begin
        if (bus.MemAck) state_nxt = IDLE;
        else if (expired) begin
`ifdef FETCH_TIMEOUT_EN
          state_nxt = ERROR;
`endif
        end
      end
`ifdef FETCH_TIMEOUT_EN
      ERROR: if (bus.Flush) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction assembly: low byte first, high byte second
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) inst_q <= '0;
    else if (cap_lo) inst_q[DATA_W-1:0]        <= bus.MemData;
    else if (cap_hi) inst_q[2*DATA_W-1:DATA_W] <= bus.MemData;
  end

  assign bus.ArfOutDSel = OUTSEL_PC;
  assign bus.ArfFunSel  = fun_sel;
  assign bus.ArfRegSel  = reg_sel;
  assign bus.MemAddr    = bus.AddrIn;
  assign bus.MemReq     = is_wait(state);
  assign bus.Inst       = inst_q;
  assign bus.InstValid  = (state == VALID);
  assign bus.Busy       = (state != IDLE);
`ifdef FETCH_TIMEOUT_EN
  assign bus.FetchErr   = (state == ERROR);
`endif
endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed table-driven bench for instruction_fetch_sequencer with a PC register-file model.
module tb_instruction_fetch_sequencer;
`ifdef FETCH_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic Clock = 1'b0;
  logic ResetN = 1'b0;
  always #5 Clock = ~Clock;

  instruction_fetch_sequencer_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  instruction_fetch_sequencer #(.ADDR_W(16), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus)
  );

  // Register file model: PC increments when PC alone is enabled with FunSel=increment
  logic [15:0] pc = 16'h0010;
  always @(posedge Clock)
    if (bus.ArfRegSel == 3'b011 && bus.ArfFunSel == 3'b001) pc <= pc + 16'h1;
  assign bus.AddrIn = pc;

  typedef struct {
    logic        st, fl, rd, ak;
    logic [7:0]  dat;
    logic        req, iv, bsy, inc;
    logic [15:0] inst, addr;
  } vec_t;

  vec_t tv[$];
  int   errors = 0;
  int   checks = 0;
  int   row    = -1;

  task automatic add(input logic st, fl, rd, ak, input logic [7:0] dat,
                     input logic req, iv, bsy, inc, input logic [15:0] inst, addr);
    vec_t v;
    v.st = st; v.fl = fl; v.rd = rd; v.ak = ak; v.dat = dat;
    v.req = req; v.iv = iv; v.bsy = bsy; v.inc = inc; v.inst = inst; v.addr = addr;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d got=%h expected=%h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic st, fl, rd, ak, input logic [7:0] dat);
    bus.Start = st; bus.Flush = fl; bus.InstReady = rd; bus.MemAck = ak; bus.MemData = dat;
  endtask

  initial begin
    drive(0, 0, 0, 0, 8'h00);

    // Stimulus table: inputs | MemReq InstValid Busy pc-inc-pulse Inst MemAddr
    // zero-wait fetch of 0x1234 at 0x0010
    add(1,0,0,0,8'h00, 0,0,0,0, 16'h0000, 16'h0010);
    add(0,0,0,1,8'h34, 1,0,1,1, 16'h0000, 16'h0010);
    add(0,0,0,1,8'h12, 1,0,1,1, 16'h0034, 16'h0011);
    add(0,0,1,0,8'h00, 0,1,1,0, 16'h1234, 16'h0012);
    add(0,0,0,0,8'h00, 0,0,0,0, 16'h1234, 16'h0012);
    // fetch 0x5678, then 5 cycles of backpressure with Start held
    add(1,0,0,0,8'h00, 0,0,0,0, 16'h1234, 16'h0012);
    add(0,0,0,1,8'h78, 1,0,1,1, 16'h1234, 16'h0012);
    add(0,0,0,1,8'h56, 1,0,1,1, 16'h1278, 16'h0013);
    for (int i = 0; i < 5; i++)
      add(1,0,0,0,8'h00, 0,1,1,0, 16'h5678, 16'h0014);
    add(1,0,1,0,8'h00, 0,1,1,0, 16'h5678, 16'h0014);
    // back-to-back fetch starts right after accept
    add(0,0,0,1,8'h9A, 1,0,1,1, 16'h5678, 16'h0014);
    add(0,0,0,1,8'hBC, 1,0,1,1, 16'h569A, 16'h0015);
    add(0,0,0,0,8'h00, 0,1,1,0, 16'hBC9A, 16'h0016);
    // Flush in VALID beats InstReady and Start
    add(1,1,1,0,8'h00, 0,1,1,0, 16'hBC9A, 16'h0016);
    add(0,0,0,0,8'h00, 0,0,0,0, 16'hBC9A, 16'h0016);
    // variable latency: low ack after 4 waits, high ack after 2 waits
    add(1,0,0,0,8'h00, 0,0,0,0, 16'hBC9A, 16'h0016);
    for (int i = 0; i < 4; i++)
      add(0,0,0,0,8'h00, 1,0,1,0, 16'hBC9A, 16'h0016);
    add(0,0,0,1,8'h11, 1,0,1,1, 16'hBC9A, 16'h0016);
    for (int i = 0; i < 2; i++)
      add(0,0,0,0,8'h00, 1,0,1,0, 16'hBC11, 16'h0017);
    add(0,0,0,1,8'h22, 1,0,1,1, 16'hBC11, 16'h0017);
    add(0,0,1,0,8'h00, 0,1,1,0, 16'h2211, 16'h0018);
    add(0,0,0,0,8'h00, 0,0,0,0, 16'h2211, 16'h0018);
    // Flush in RD_HI before ack -> DRAIN, 0xAA discarded, no PC bump
    add(1,0,0,0,8'h00, 0,0,0,0, 16'h2211, 16'h0018);
    add(0,0,0,1,8'h01, 1,0,1,1, 16'h2211, 16'h0018);
    add(0,1,0,0,8'h00, 1,0,1,0, 16'h2201, 16'h0019);
    add(0,0,0,0,8'h00, 1,0,1,0, 16'h2201, 16'h0019);
    add(0,0,0,1,8'hAA, 1,0,1,0, 16'h2201, 16'h0019);
    add(0,0,0,0,8'h00, 0,0,0,0, 16'h2201, 16'h0019);
    // Flush together with ack in RD_LO -> IDLE, no capture, no PC bump
    add(1,0,0,0,8'h00, 0,0,0,0, 16'h2201, 16'h0019);
    add(0,1,0,1,8'h55, 1,0,1,0, 16'h2201, 16'h0019);
    add(0,0,0,0,8'h00, 0,0,0,0, 16'h2201, 16'h0019);
    // Flush ignored in DRAIN; ack in IDLE ignored
    add(1,0,0,0,8'h00, 0,0,0,0, 16'h2201, 16'h0019);
    add(0,1,0,0,8'h00, 1,0,1,0, 16'h2201, 16'h0019);
    add(0,1,0,0,8'h00, 1,0,1,0, 16'h2201, 16'h0019);
    add(0,0,0,1,8'h66, 1,0,1,0, 16'h2201, 16'h0019);
    add(0,0,0,1,8'h77, 0,0,0,0, 16'h2201, 16'h0019);
    add(0,0,0,0,8'h00, 0,0,0,0, 16'h2201, 16'h0019);

    // Reset state
    repeat (2) @(negedge Clock);
    #1;
    chk("rst_memreq", 16'(bus.MemReq), 16'h0);
    chk("rst_valid",  16'(bus.InstValid), 16'h0);
    chk("rst_busy",   16'(bus.Busy), 16'h0);
    chk("rst_regsel", 16'(bus.ArfRegSel), 16'h7);
    chk("rst_funsel", 16'(bus.ArfFunSel), 16'h0);
    chk("rst_inst",   bus.Inst, 16'h0000);
    chk("rst_outsel", 16'(bus.ArfOutDSel), 16'h0);
    @(negedge Clock);
    ResetN = 1'b1;

    foreach (tv[i]) begin
      @(negedge Clock);
      row = i;
      drive(tv[i].st, tv[i].fl, tv[i].rd, tv[i].ak, tv[i].dat);
      #1;
      chk("memreq", 16'(bus.MemReq), 16'(tv[i].req));
      chk("valid",  16'(bus.InstValid), 16'(tv[i].iv));
      chk("busy",   16'(bus.Busy), 16'(tv[i].bsy));
      chk("regsel", 16'(bus.ArfRegSel), tv[i].inc ? 16'h3 : 16'h7);
      chk("funsel", 16'(bus.ArfFunSel), tv[i].inc ? 16'h1 : 16'h0);
      chk("inst",   bus.Inst, tv[i].inst);
      chk("memaddr", bus.MemAddr, tv[i].addr);
    end

    // Async reset between edges while in RD_LO
    row = 1000;
    @(negedge Clock);
    drive(1, 0, 0, 0, 8'h00);
    @(negedge Clock);
    drive(0, 0, 0, 0, 8'h00);
    #1;
    chk("pre_rst_memreq", 16'(bus.MemReq), 16'h1);
    #2;
    ResetN = 1'b0;
    #1;
    chk("arst_memreq", 16'(bus.MemReq), 16'h0);
    chk("arst_valid",  16'(bus.InstValid), 16'h0);
    chk("arst_busy",   16'(bus.Busy), 16'h0);
    chk("arst_regsel", 16'(bus.ArfRegSel), 16'h7);
    chk("arst_inst",   bus.Inst, 16'h0000);
    @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);
    #1;
    chk("post_rst_busy", 16'(bus.Busy), 16'h0);

`ifdef FETCH_TIMEOUT_EN
    // No ack: 8 wait cycles, then ERROR until Flush
    row = 2000;
    @(negedge Clock);
    drive(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      drive(0, 0, 0, 0, 8'h00);
      #1;
      chk("to_wait_memreq", 16'(bus.MemReq), 16'h1);
      chk("to_wait_err",    16'(bus.FetchErr), 16'h0);
    end
    @(negedge Clock);
    drive(0, 1, 0, 0, 8'h00);
    #1;
    chk("to_err",        16'(bus.FetchErr), 16'h1);
    chk("to_err_memreq", 16'(bus.MemReq), 16'h0);
    chk("to_err_busy",   16'(bus.Busy), 16'h1);
    @(negedge Clock);
    drive(0, 0, 0, 0, 8'h00);
    #1;
    chk("to_clr_err",  16'(bus.FetchErr), 16'h0);
    chk("to_clr_busy", 16'(bus.Busy), 16'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
